// File: rtl/aux_pkg.sv
// aux_pkg: shared types and constants for the auxiliary instruction fetch block.
//   aux_state_e   - fetch controller FSM states
//   AXI_RESP_OKAY - AXI read response code for a successful beat
//   BOUNDARY_4K   - AXI bursts must not cross this byte boundary
//   min_u32()     - unsigned minimum helper used for burst sizing
package aux_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StArb,
        StAddr,
        StData,
        StDrain
    } aux_state_e;

    localparam logic [1:0]  AXI_RESP_OKAY = 2'b00;
    localparam int unsigned BOUNDARY_4K   = 4096;

    function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/aux_fifo.sv
// aux_fifo: synchronous first-word-fall-through FIFO with occupancy output.
//   clk, rst_n     - clock, synchronous active-low reset (flushes contents)
//   push, wdata    - write strobe and data (ignored when full)
//   pop            - read strobe (ignored when empty)
//   rvalid, rdata  - head-of-queue valid and data, visible without a pop
//   count          - current occupancy, 0..DEPTH
// DEPTH must be a power of two and at least 2.
module aux_fifo #(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned WIDTH = 128
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wdata,
    input  logic                     pop,
    output logic                     rvalid,
    output logic [WIDTH-1:0]         rdata,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push && (count_q != (PTR_W + 1)'(DEPTH));
    assign pop_ok  = pop && (count_q != '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= wdata;
    end

    assign rvalid = (count_q != '0);
    assign rdata  = mem[rd_ptr_q];
    assign count  = count_q;

endmodule

// File: rtl/aux_instr_mc.sv
// aux_instr_mc: multi-channel instruction fetcher. On ap_start each channel's
// beat count and base address are latched; the controller then issues AXI read
// bursts round-robin across channels, only when the channel FIFO can absorb the
// whole burst, and streams the beats out on per-channel AXIS ports.
//   clk, rst_n                    - clock, synchronous active-low reset
//   ap_start/done/idle/ready      - HLS-style block control
//   num_instr, base_addr          - per-channel beat count and aligned byte address
//   status                        - [31] sticky rresp error, [30] busy, [29:0] beats popped
//   m_axi_ar*, m_axi_r*           - AXI read master (single outstanding burst)
//   m_instr_t*                    - per-channel AXIS instruction streams
//   perf_stall                    - per-channel tvalid&~tready cycle counters, present only
//                                   when AUX_INSTR_MC_PERF_EN is defined
module aux_instr_mc
    import aux_pkg::*;
#(
    parameter int unsigned AXI_ADDR_WIDTH = 64,
    parameter int unsigned AXI_DATA_WIDTH = 128,
    parameter int unsigned NUM_CH         = 2,
    parameter int unsigned FIFO_DEPTH     = 256,
    parameter int unsigned MAX_BURST      = 16
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    ap_start,
    output logic                                    ap_done,
    output logic                                    ap_idle,
    output logic                                    ap_ready,
    input  logic [NUM_CH-1:0][31:0]                 num_instr,
    input  logic [NUM_CH-1:0][AXI_ADDR_WIDTH-1:0]   base_addr,
    output logic [NUM_CH-1:0][31:0]                 status,
    input  logic                                    m_axi_arready,
    output logic                                    m_axi_arvalid,
    output logic [AXI_ADDR_WIDTH-1:0]               m_axi_araddr,
    output logic [7:0]                              m_axi_arlen,
    output logic                                    m_axi_rready,
    input  logic                                    m_axi_rvalid,
    input  logic [AXI_DATA_WIDTH-1:0]               m_axi_rdata,
    input  logic [1:0]                              m_axi_rresp,
    input  logic                                    m_axi_rlast,
    input  logic [NUM_CH-1:0]                       m_instr_tready,
    output logic [NUM_CH-1:0]                       m_instr_tvalid,
    output logic [NUM_CH-1:0][AXI_DATA_WIDTH-1:0]   m_instr_tdata
`ifdef AUX_INSTR_MC_PERF_EN
    ,
    output logic [NUM_CH-1:0][31:0]                 perf_stall
`endif
);

    localparam int unsigned BEAT_BYTES = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W      = $clog2(BEAT_BYTES);
    localparam int unsigned CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;

    aux_state_e state_q, state_d;

    logic [NUM_CH-1:0][31:0]               remaining_q;
    logic [NUM_CH-1:0][AXI_ADDR_WIDTH-1:0] addr_q;
    logic [NUM_CH-1:0]                     err_q;
    logic [NUM_CH-1:0][29:0]               pop_cnt_q;
    logic [CH_W-1:0]                       grant_q;
    logic [CH_W-1:0]                       last_q;
    logic [8:0]                            len_q;
    logic [8:0]                            inflight_q;

    logic [NUM_CH-1:0][CNT_W-1:0]          fifo_count;
    logic [NUM_CH-1:0][8:0]                len_c;
    logic [NUM_CH-1:0]                     elig;
    logic [NUM_CH-1:0]                     push;
    logic [NUM_CH-1:0]                     pop;
    logic                                  found;
    logic [CH_W-1:0]                       pick;
    logic                                  any_rem;
    logic                                  all_empty;

    // Burst sizing and eligibility per channel. Beats still owed by the
    // in-flight burst count against free space so the FIFO can never overflow.
    always_comb begin
        logic [31:0] to_4k;
        logic [31:0] reserved;
        logic [31:0] free;
        any_rem   = 1'b0;
        all_empty = 1'b1;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            to_4k    = (32'(BOUNDARY_4K) - {20'd0, addr_q[c][11:0]}) >> OFF_W;
            len_c[c] = 9'(min_u32(min_u32(remaining_q[c], 32'(MAX_BURST)), to_4k));
            reserved = ((state_q == StAddr || state_q == StData) && grant_q == CH_W'(c))
                       ? 32'(inflight_q) : 32'd0;
            free     = 32'(FIFO_DEPTH) - 32'(fifo_count[c]) - reserved;
            elig[c]  = (remaining_q[c] != 32'd0) && (free >= 32'(len_c[c]));
            if (remaining_q[c] != 32'd0) any_rem = 1'b1;
            if (fifo_count[c] != '0) all_empty = 1'b0;
        end
    end

    // Round-robin search begins one past the last granted channel.
    always_comb begin
        int unsigned idx;
        found = 1'b0;
        pick  = '0;
        for (int unsigned i = 1; i <= NUM_CH; i++) begin
            idx = (int'(last_q) + i) % NUM_CH;
            if (!found && elig[CH_W'(idx)]) begin
                found = 1'b1;
                pick  = CH_W'(idx);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (ap_start) state_d = StArb;
            StArb: begin
                if (found)         state_d = StAddr;
                else if (!any_rem) state_d = StDrain;
            end
            StAddr:  if (m_axi_arready) state_d = StData;
            StData:  if (m_axi_rvalid && m_axi_rlast) state_d = StArb;
            StDrain: if (all_empty) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= StIdle;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            remaining_q <= '0;
            addr_q      <= '0;
            err_q       <= '0;
            pop_cnt_q   <= '0;
            grant_q     <= '0;
            last_q      <= CH_W'(NUM_CH - 1);
            len_q       <= '0;
            inflight_q  <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (pop[c]) pop_cnt_q[c] <= pop_cnt_q[c] + 30'd1;
            end
            unique case (state_q)
                StIdle: begin
                    if (ap_start) begin
                        remaining_q <= num_instr;
                        addr_q      <= base_addr;
                        err_q       <= '0;
                        pop_cnt_q   <= '0;
                    end
                end
                StArb: begin
                    if (found) begin
                        grant_q    <= pick;
                        last_q     <= pick;
                        len_q      <= len_c[pick];
                        inflight_q <= len_c[pick];
                    end
                end
                StAddr: begin
                    if (m_axi_arready) begin
                        addr_q[grant_q]      <= addr_q[grant_q]
                                                + (AXI_ADDR_WIDTH'(len_q) << OFF_W);
                        remaining_q[grant_q] <= remaining_q[grant_q] - 32'(len_q);
                    end
                end
                StData: begin
                    if (m_axi_rvalid) begin
                        inflight_q <= inflight_q - 9'd1;
                        if (m_axi_rresp != AXI_RESP_OKAY) err_q[grant_q] <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        assign push[c] = (state_q == StData) && m_axi_rvalid && (grant_q == CH_W'(c));
        assign pop[c]  = m_instr_tvalid[c] && m_instr_tready[c];

        aux_fifo #(
            .DEPTH (FIFO_DEPTH),
            .WIDTH (AXI_DATA_WIDTH)
        ) u_fifo (
            .clk    (clk),
            .rst_n  (rst_n),
            .push   (push[c]),
            .wdata  (m_axi_rdata),
            .pop    (pop[c]),
            .rvalid (m_instr_tvalid[c]),
            .rdata  (m_instr_tdata[c]),
            .count  (fifo_count[c])
        );

        assign status[c] = {err_q[c],
                            (remaining_q[c] != 32'd0) || (fifo_count[c] != '0),
                            pop_cnt_q[c]};
    end

    assign m_axi_arvalid = (state_q == StAddr);
    assign m_axi_araddr  = addr_q[grant_q];
    assign m_axi_arlen   = 8'(len_q - 9'd1);
    assign m_axi_rready  = (state_q == StData);
    assign ap_idle       = (state_q == StIdle);
    assign ap_done       = (state_q == StDrain) && all_empty;
    assign ap_ready      = ap_done;

`ifdef AUX_INSTR_MC_PERF_EN
    logic [NUM_CH-1:0][31:0] stall_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (state_q == StIdle && ap_start) begin
            stall_q <= '0;
        end else begin
            for (int unsigned c = 0; c < NUM_CH; c++) begin
                if (m_instr_tvalid[c] && !m_instr_tready[c]) stall_q[c] <= stall_q[c] + 32'd1;
            end
        end
    end

    assign perf_stall = stall_q;
`endif

endmodule
